hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: id_rs1, id_rs2  input  5 each  source registers of instruction in ID.
REQ-004 SHALL provide: id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-005 SHALL provide: ex_rd  input  5  destination register of instruction in EX.
REQ-006 SHALL provide: ex_is_load  input  1  EX instruction is a load (opcode 0000011).
REQ-007 SHALL provide: ex_redirect  input  1  taken branch, JAL or JALR resolved in EX.
REQ-008 SHALL provide: dmem_req, dmem_ready  input  1 each  data-memory request and completion handshake.
REQ-009 SHALL provide: imem_ready  input  1  fetch data valid this cycle.
REQ-010 SHALL provide: pc_we, if_id_we, id_ex_we, ex_mem_we  output  1 each  stage-register write enables.
REQ-011 SHALL provide: pc_sel  output  1  1 selects the EX redirect target for the next PC.
REQ-012 SHALL provide: if_id_flush, id_ex_flush  output  1 each  load a bubble (NOP) into the stage register.
REQ-013 SHALL provide: ctrl_state  output  2  current FSM state: BOOT=00, RUN=01, DWAIT=10.
REQ-014 SHALL provide: stall_cycles, redirect_count  output  32 each  performance counters.

Function
REQ-015 The FSM SHALL have states BOOT, RUN and DWAIT.
REQ-016 BOOT SHALL last exactly one cycle, then go to RUN.
REQ-017 In BOOT: pc_we=0, if_id_flush=1, id_ex_flush=1, pc_sel=0, and the other enables =0.
REQ-018 RUN SHALL go to DWAIT on a cycle with dmem_req=1 and dmem_ready=0.
REQ-019 DWAIT SHALL return to RUN on the first cycle with dmem_ready=1.
REQ-020 In DWAIT all four enables and both flushes SHALL be 0 (full freeze). ex_redirect, load-use and imem_ready SHALL be ignored.
REQ-021 The cycle that enters DWAIT SHALL already drive the DWAIT outputs (freeze is combinational on dmem_req & !dmem_ready).
REQ-022 Load-use hazard SHALL be defined as ex_is_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-023 In RUN, priority SHALL be: dmem freeze > ex_redirect > load-use > imem wait > normal.
REQ-024 Redirect: pc_sel=1, pc_we=1, if_id_flush=1, id_ex_flush=1, ex_mem_we=1.
REQ-025 Load-use: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1. This gives exactly one bubble cycle.
REQ-026 Imem wait (imem_ready=0): pc_we=0, if_id_flush=1, id_ex_we=1, ex_mem_we=1.
REQ-027 Normal: all enables =1, flushes =0, pc_sel=0.
REQ-028 A flush SHALL take precedence over the write enable of the same stage register.
REQ-029 Register x0 SHALL never cause a load-use stall.

Reset
REQ-030 While rst_n=0, the state SHALL be BOOT and all enables and pc_sel SHALL be 0.
REQ-031 While rst_n=0, both flushes SHALL be 1 and both counters SHALL be 0.
REQ-032 Reset asserted in any state, including mid-DWAIT, SHALL take effect immediately with no pending-state carry-over.
REQ-033 After rst_n rises, the first clock edge SHALL move the FSM from BOOT to RUN.

Configuration
REQ-034 With macro HAZARD_PERF_EN defined, stall_cycles SHALL increment on every non-BOOT cycle with pc_we=0.
REQ-035 With HAZARD_PERF_EN defined, redirect_count SHALL increment on every RUN cycle where a redirect is applied.
REQ-036 With HAZARD_PERF_EN defined, both counters SHALL wrap modulo 2^32.
REQ-037 Without HAZARD_PERF_EN, the ports SHALL remain and be tied to 0, and no counter flops SHALL be built.

Verification
REQ-038 Reset release scenario: one BOOT cycle with ctrl_state=00 and both flushes =1, then ctrl_state=01 with all enables =1.
REQ-039 Load-use scenario: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1. Repeat with ex_rd=0 -> no stall.
REQ-040 Redirect vs load-use scenario: redirect and load-use in the same cycle -> pc_sel=1 and both flushes =1. redirect_count +1 when HAZARD_PERF_EN is defined.
REQ-041 Data-memory wait scenario: dmem_req=1 with dmem_ready=0 for 3 cycles -> enables =0 for 3 cycles, ctrl_state=10, ex_redirect ignored. dmem_ready=1 -> RUN. stall_cycles +3 when HAZARD_PERF_EN is defined.
REQ-042 Fetch wait scenario: imem_ready=0 -> pc_we=0, if_id_flush=1, id_ex_we=1.
REQ-043 Reset mid-operation scenario: rst_n dropped during DWAIT -> immediate BOOT outputs and counters =0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a five-stage in-order core. It decides, every
// cycle, which stage registers advance, which get a bubble, and whether the
// next PC comes from the EX redirect target. Covered cases are data-memory
// wait (full freeze), EX redirect, load-use and instruction-fetch wait.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1/id_rs2, id_uses_*   source registers of the ID instruction
//   ex_rd, ex_is_load          destination / load flag of the EX instruction
//   ex_redirect                taken branch / JAL / JALR resolved in EX
//   dmem_req, dmem_ready       data-memory handshake
//   imem_ready                 fetch data valid this cycle
//   pc_we, if_id_we,
//   id_ex_we, ex_mem_we        stage-register write enables
//   pc_sel                     1 = next PC is the EX redirect target
//   if_id_flush, id_ex_flush   load a bubble into the stage register
//   ctrl_state                 BOOT=00, RUN=01, DWAIT=10
//   stall_cycles,
//   redirect_count             performance counters
//
// Build option
//   HAZARD_PERF_EN  when defined, the two performance counters are built;
//                   otherwise both counter ports are tied to zero.
// ----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        id_ex_we,
   output logic        ex_mem_we,
   output logic        pc_sel,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic [1:0]  ctrl_state,
   output logic [31:0] stall_cycles,
   output logic [31:0] redirect_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      RUN   = 2'b01,
      DWAIT = 2'b10
   } state_t;

   state_t state_r;

   logic load_use_s;
   logic freeze_s;
   logic pc_we_s;
   logic if_id_we_s;
   logic id_ex_we_s;
   logic ex_mem_we_s;
   logic pc_sel_s;
   logic if_id_flush_s;
   logic id_ex_flush_s;

   // Load-use detection; x0 is hard-wired zero so it never creates a dependency.
   always_comb begin
      load_use_s = ex_is_load & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd)));
   end

   // Freeze condition: in RUN it is the un-acknowledged request itself, so the
   // entering cycle is already frozen; in DWAIT it holds until dmem_ready.
   always_comb begin
      case (state_r)
         RUN:     freeze_s = dmem_req & ~dmem_ready;
         DWAIT:   freeze_s = ~dmem_ready;
         default: freeze_s = 1'b0;
      endcase
   end

   // Control decode in priority order: freeze > redirect > load-use > fetch wait.
   // Outputs are combinational so a hazard acts in the same cycle it is seen.
   always_comb begin
      pc_we_s       = 1'b0;
      if_id_we_s    = 1'b0;
      id_ex_we_s    = 1'b0;
      ex_mem_we_s   = 1'b0;
      pc_sel_s      = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      case (state_r)
         BOOT: begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
         end
         RUN, DWAIT: begin
            if (freeze_s) begin
               pc_we_s = 1'b0;
            end else if (ex_redirect) begin
               pc_sel_s      = 1'b1;
               pc_we_s       = 1'b1;
               if_id_flush_s = 1'b1;
               id_ex_flush_s = 1'b1;
               ex_mem_we_s   = 1'b1;
            end else if (load_use_s) begin
               // Hold PC and IF/ID, bubble into EX: exactly one lost cycle.
               id_ex_flush_s = 1'b1;
               ex_mem_we_s   = 1'b1;
            end else if (!imem_ready) begin
               if_id_flush_s = 1'b1;
               id_ex_we_s    = 1'b1;
               ex_mem_we_s   = 1'b1;
            end else begin
               pc_we_s     = 1'b1;
               if_id_we_s  = 1'b1;
               id_ex_we_s  = 1'b1;
               ex_mem_we_s = 1'b1;
            end
         end
         default: begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
         end
      endcase
   end

   // A flush wins over the write enable of the same stage register.
   assign pc_we       = pc_we_s;
   assign if_id_we    = if_id_we_s & ~if_id_flush_s;
   assign id_ex_we    = id_ex_we_s & ~id_ex_flush_s;
   assign ex_mem_we   = ex_mem_we_s;
   assign pc_sel      = pc_sel_s;
   assign if_id_flush = if_id_flush_s;
   assign id_ex_flush = id_ex_flush_s;
   assign ctrl_state  = state_r;

   // Controller FSM: one BOOT cycle, then RUN, with DWAIT for data-memory waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= BOOT;
      end else begin
         case (state_r)
            BOOT:    state_r <= RUN;
            RUN:     state_r <= (dmem_req & ~dmem_ready) ? DWAIT : RUN;
            DWAIT:   state_r <= dmem_ready ? RUN : DWAIT;
            default: state_r <= BOOT;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_r;
   logic [31:0] redirect_count_r;

   // Performance counters; pc_sel is high exactly when a redirect is applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_r   <= 32'd0;
         redirect_count_r <= 32'd0;
      end else begin
         if ((state_r != BOOT) && !pc_we_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
         if (pc_sel_s) begin
            redirect_count_r <= redirect_count_r + 32'd1;
         end else begin
            redirect_count_r <= redirect_count_r;
         end
      end
   end

   assign stall_cycles   = stall_cycles_r;
   assign redirect_count = redirect_count_r;
`else
   assign stall_cycles   = 32'd0;
   assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a directed vector table for the RUN
// priority rules, hand-written sequences for reset release, data-memory wait
// and reset during a wait, and a randomized run against a rule-level model.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
   logic        dmem_req, dmem_ready, imem_ready;
   logic        pc_we, if_id_we, id_ex_we, ex_mem_we, pc_sel, if_id_flush, id_ex_flush;
   logic [1:0]  ctrl_state;
   logic [31:0] stall_cycles, redirect_count;
   logic [6:0]  dut_out;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
      .pc_sel(pc_sel), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
   );

   // Packed view: {pc_we, if_id_we, id_ex_we, ex_mem_we, pc_sel, if_id_flush, id_ex_flush}
   assign dut_out = {pc_we, if_id_we, id_ex_we, ex_mem_we, pc_sel, if_id_flush, id_ex_flush};

   int pass_cnt = 0;
   int total_cnt = 0;

   // Model: "booting" = the single post-reset cycle, "waiting" = memory wait pending.
   bit          m_booting = 1'b1;
   bit          m_waiting = 1'b0;
   logic [31:0] exp_stall = 32'd0;
   logic [31:0] exp_redir = 32'd0;

   typedef struct {
      string      name;
      logic       redir, is_load;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, imem, dreq, drdy;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input string n, input logic redir, input logic ld,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic imem,
                               input logic dreq, input logic drdy, input logic [6:0] exp);
      vec_t v;
      v.name = n; v.redir = redir; v.is_load = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.imem = imem; v.dreq = dreq; v.drdy = drdy; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Rule-level expectation for the current cycle.
   function automatic logic [6:0] model_out();
      bit dep;
      bit frozen;
      dep = ex_is_load && (ex_rd != 5'd0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      frozen = m_waiting ? !dmem_ready : (dmem_req && !dmem_ready);
      if (!rst_n || m_booting) return 7'b0000011;
      if (frozen)              return 7'b0000000;
      if (ex_redirect)         return 7'b1001111;
      if (dep)                 return 7'b0001001;
      if (!imem_ready)         return 7'b0011010;
      return 7'b1111000;
   endfunction

   task automatic set_idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   // Called at posedge+1: checks mid-cycle, advances the model, returns at next posedge+1.
   task automatic tick(input string tag, input bit has_tbl, input logic [6:0] tbl);
      logic [6:0] e;
      logic [1:0] es;
      #4;
      e  = model_out();
      es = m_booting ? 2'b00 : (m_waiting ? 2'b10 : 2'b01);
      check({tag, ".outs"}, 64'(dut_out), 64'(e));
      if (has_tbl) check({tag, ".table"}, 64'(dut_out), 64'(tbl));
      check({tag, ".state"}, 64'(ctrl_state), 64'(es));
      check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(exp_stall));
      check({tag, ".redirect_count"}, 64'(redirect_count), 64'(exp_redir));
`ifdef HAZARD_PERF_EN
      if (!m_booting && !e[6]) exp_stall = exp_stall + 32'd1;
      if (e[2])                exp_redir = exp_redir + 32'd1;
`endif
      if (m_booting)          m_booting = 1'b0;
      else if (m_waiting)     m_waiting = !dmem_ready;
      else                    m_waiting = dmem_req && !dmem_ready;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must take BOOT values without waiting for a clock.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, ".rst_outs"}, 64'(dut_out), 64'(7'b0000011));
      check({tag, ".rst_state"}, 64'(ctrl_state), 64'(2'b00));
      check({tag, ".rst_stall"}, 64'(stall_cycles), 64'(32'd0));
      check({tag, ".rst_redir"}, 64'(redirect_count), 64'(32'd0));
      m_booting = 1'b1; m_waiting = 1'b0; exp_stall = 32'd0; exp_redir = 32'd0;
      @(posedge clk);
      #1;
      check({tag, ".rst_hold"}, 64'(dut_out), 64'(7'b0000011));
      check({tag, ".rst_hold_state"}, 64'(ctrl_state), 64'(2'b00));
      rst_n = 1'b1;
   endtask

   initial begin
      set_idle();
      //            name         red ld  rd     rs1    rs2    u1 u2 im dq dr  expected
      vecs[0]  = mk("normal",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 1, 7'b1111000);
      vecs[1]  = mk("lu_rs1",     0, 1, 5'd5,  5'd5,  5'd1,  1, 0, 1, 0, 1, 7'b0001001);
      vecs[2]  = mk("lu_rs2",     0, 1, 5'd7,  5'd2,  5'd7,  0, 1, 1, 0, 1, 7'b0001001);
      vecs[3]  = mk("lu_x0",      0, 1, 5'd0,  5'd0,  5'd0,  1, 1, 1, 0, 1, 7'b1111000);
      vecs[4]  = mk("lu_unused",  0, 1, 5'd5,  5'd5,  5'd5,  0, 0, 1, 0, 1, 7'b1111000);
      vecs[5]  = mk("not_load",   0, 0, 5'd5,  5'd5,  5'd1,  1, 0, 1, 0, 1, 7'b1111000);
      vecs[6]  = mk("redirect",   1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 1, 7'b1001111);
      vecs[7]  = mk("redir_lu",   1, 1, 5'd5,  5'd5,  5'd1,  1, 0, 1, 0, 1, 7'b1001111);
      vecs[8]  = mk("imem_wait",  0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 1, 7'b0011010);
      vecs[9]  = mk("lu_imem",    0, 1, 5'd9,  5'd3,  5'd9,  0, 1, 0, 0, 1, 7'b0001001);
      vecs[10] = mk("redir_imem", 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 1, 7'b1001111);
      vecs[11] = mk("dmem_hit",   0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 1, 1, 7'b1111000);

      // Reset release: one BOOT cycle, then RUN with all enables set.
      @(posedge clk);
      #1;
      apply_reset("por");
      tick("boot", 1'b1, 7'b0000011);
      tick("run0", 1'b1, 7'b1111000);

      // Directed RUN priority table.
      for (int i = 0; i < 12; i++) begin
         ex_redirect = vecs[i].redir; ex_is_load = vecs[i].is_load; ex_rd = vecs[i].rd;
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; imem_ready = vecs[i].imem;
         dmem_req = vecs[i].dreq; dmem_ready = vecs[i].drdy;
         tick(vecs[i].name, 1'b1, vecs[i].exp);
      end

      // Data-memory wait for three cycles with a redirect that must be ignored.
      set_idle();
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
      repeat (3) tick("dwait", 1'b1, 7'b0000000);
      dmem_ready = 1'b1; ex_redirect = 1'b0;
      tick("dwait_done", 1'b1, 7'b1111000);
      set_idle();
      tick("after_wait", 1'b1, 7'b1111000);

      // Reset dropped in the middle of a wait.
      dmem_req = 1'b1; dmem_ready = 1'b0;
      tick("mid_enter", 1'b1, 7'b0000000);
      tick("mid_wait", 1'b1, 7'b0000000);
      apply_reset("mid");
      tick("mid_boot", 1'b1, 7'b0000011);
      set_idle();
      tick("mid_run", 1'b1, 7'b1111000);

      // Randomized traffic against the model, with occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) apply_reset("rrst");
         ex_rd       = 5'($urandom_range(0, 3));
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom_range(0, 1));
         id_uses_rs2 = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 7) == 0);
         imem_ready  = ($urandom_range(0, 3) != 0);
         dmem_req    = ($urandom_range(0, 3) == 0);
         dmem_ready  = 1'($urandom_range(0, 1));
         tick("rand", 1'b0, 7'b0000000);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
